nabp_shifter: RTL and testbench
===============================

# nabp_shifter

Shifter stage downstream of the NABP state control. On a fill kick it loads a chain of `NUM_PE` projection samples from the projection line buffer. On a shift kick it runs a fixed-length shift pass, advancing the chain by fixed-point accumulation of `sh_accu_base`. It feeds the chain to the processing elements and returns one-cycle `sh_fill_done` / `sh_shift_done` pulses to the state control.

## Interface
- `DATA_WIDTH`, 16: projection sample width
- `NUM_PE`, 8: chain length / PE lane count (≥2)
- `ADDR_WIDTH`, 9: projection buffer address width
- `PB_DEPTH`, 512: valid buffer entries, addresses 0..PB_DEPTH-1 (≤2^ADDR_WIDTH)
- `SHIFT_LEN`, 256: cycles per shift pass
- `FRAC_BITS`, 8: accumulator fraction bits
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `sh_fill_kick`  in  1  start fill, sampled in IDLE
- `sh_shift_kick`  in  1  start shift pass, sampled in IDLE
- `sh_accu_base`  in  FRAC_BITS+1  shift increment, unsigned Q1.FRAC_BITS
- `sh_fill_done`  out  1  fill complete pulse
- `sh_shift_done`  out  1  shift pass complete pulse
- `pb_en`  out  1  buffer read enable
- `pb_addr`  out  ADDR_WIDTH  buffer read address (registered)
- `pb_data`  in  DATA_WIDTH  read data, valid the cycle after `pb_en`
- `pe_data`  out  NUM_PE*DATA_WIDTH  chain; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- `pe_shift`  out  1  chain advances at end of this cycle

## Operation
- Reset (async) values: state IDLE, chain all zero, `pb_addr`=0, accumulator 0, counters 0, pending 0, all single-bit outputs 0.
- States:
  - IDLE:
    - `sh_fill_kick` → FILL, `pb_addr`←0.
    - else `sh_shift_kick` → SHIFT, accumulator←0, cycle count←0, latch `sh_accu_base`.
    - Fill wins if both kicks are high. Kicks outside IDLE are ignored.
  - FILL: `pb_en`=1 every cycle, `pb_addr` increments after each read; after NUM_PE reads → FILL_LAST.
  - FILL_LAST: one cycle, `sh_fill_done`=1, captures the last sample → IDLE.
  - SHIFT: SHIFT_LEN cycles, then → SHIFT_LAST.
  - SHIFT_LAST: one cycle, `sh_shift_done`=1, captures any outstanding sample → IDLE.
- Chain capture, on each sample arrival (cycle after a read or after a shift carry):
  - lane i ← lane i+1 for i < NUM_PE-1; lane NUM_PE-1 ← new sample; old lane 0 is dropped.
  - `pe_shift`=1 in that cycle. Fill captures also assert `pe_shift`.
- Shift accumulation, each SHIFT cycle:
  - sum = frac + base, where frac is FRAC_BITS wide.
  - carry = sum ≥ 2^FRAC_BITS; frac ← sum mod 2^FRAC_BITS.
  - On carry: issue one read (`pb_en`=1 if `pb_addr` < PB_DEPTH), then `pb_addr`++ (saturates at PB_DEPTH), and set pending.
- Base clamping: base > 2^FRAC_BITS is clamped to 2^FRAC_BITS, giving at most one shift per cycle. Base 0 never shifts.
- Out-of-range address: a carry with `pb_addr` ≥ PB_DEPTH issues no read but still shifts, with the new sample = 0.
- `pb_en` is combinational from state and carry. All other outputs are registered or pure state decodes.
- `pb_addr` is not reset by a shift kick; a pass continues from where the fill ended.

## Timing
- Kick sampled at the edge ending cycle 0.
- Fill:
  - `pb_en` in cycles 1..NUM_PE, addresses 0..NUM_PE-1.
  - `sh_fill_done` high in cycle NUM_PE+1 only; the chain is complete after that edge.
  - Back in IDLE at cycle NUM_PE+2.
- Shift:
  - SHIFT occupies cycles 1..SHIFT_LEN; `sh_shift_done` high in cycle SHIFT_LEN+1 only.
  - `pe_shift` lags its carry/read by exactly 1 cycle.
  - A carry in cycle SHIFT_LEN is captured in SHIFT_LAST.
- Done pulses are exactly one cycle wide and never overlap.
- Reset mid-operation: all outputs drop immediately, without waiting for a clock edge. The next kick behaves as from power-up.

## Test plan
Common bench setup: NUM_PE=4, FRAC_BITS=4, SHIFT_LEN=8, PB_DEPTH=16, buffer model mem[k]=k+1.
- Fill: fill kick in cycle 0 → `pb_en` in cycles 1–4 at addresses 0..3; `sh_fill_done` in cycle 5 only; lanes 0..3 = 1,2,3,4.
- Full-rate shift (base=16), after fill → reads of addresses 4..11 in cycles 1–8; `pe_shift` in cycles 2–9; `sh_shift_done` in cycle 9; lanes = 9,10,11,12.
- Half-rate shift (base=8), after fill → reads only in cycles 2,4,6,8 at addresses 4..7; lanes = 5,6,7,8. Base=0 → no `pb_en`, no `pe_shift`, `sh_shift_done` in cycle 9, lanes unchanged.
- Buffer end (PB_DEPTH=6), fill then base=16 → only addresses 4,5 are read; 8 shifts occur; lanes = 0,0,0,0; `pb_addr` holds at 6.
- Kick arbitration: both kicks together in IDLE → FILL only. Shift kick during FILL → ignored; no extra done pulse.
- Async reset in cycle 2 of a fill → `pb_en`, done pulses and `pe_data` go to 0 before the next edge. A subsequent fill kick starts at address 0 with identical timing.

Source files
------------

// File: rtl/nabp_shifter_if.sv
// rtl/nabp_shifter_if.sv - state-control, projection-buffer and PE-chain signals of the NABP shifter
//   sh_fill_kick / sh_shift_kick / sh_accu_base : requests from the state control
//   sh_fill_done / sh_shift_done                : one-cycle completion pulses back to it
//   pb_en / pb_addr / pb_data                   : projection line buffer read port
//   pe_data / pe_shift                          : sample chain and advance strobe to the PEs
//   master = environment side (state control, buffer, PEs); slave = shifter
interface nabp_shifter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int FRAC_BITS  = 8
);
   logic                         sh_fill_kick;
   logic                         sh_shift_kick;
   logic [FRAC_BITS:0]           sh_accu_base;
   logic                         sh_fill_done;
   logic                         sh_shift_done;
   logic                         pb_en;
   logic [ADDR_WIDTH-1:0]        pb_addr;
   logic [DATA_WIDTH-1:0]        pb_data;
   logic [NUM_PE*DATA_WIDTH-1:0] pe_data;
   logic                         pe_shift;

   modport master (
      output sh_fill_kick, sh_shift_kick, sh_accu_base, pb_data,
      input  sh_fill_done, sh_shift_done, pb_en, pb_addr, pe_data, pe_shift
   );

   modport slave (
      input  sh_fill_kick, sh_shift_kick, sh_accu_base, pb_data,
      output sh_fill_done, sh_shift_done, pb_en, pb_addr, pe_data, pe_shift
   );
endinterface

// File: rtl/nabp_shifter.sv
// rtl/nabp_shifter.sv - NABP shifter: fills the PE sample chain and runs fixed-length shift passes
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : nabp_shifter_if.slave (kicks/base in, done pulses out, buffer read port, PE chain out)
module nabp_shifter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int PB_DEPTH   = 512,
   parameter int SHIFT_LEN  = 256,
   parameter int FRAC_BITS  = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   nabp_shifter_if.slave  bus
);
   localparam int CNT_W = $clog2(SHIFT_LEN + NUM_PE + 1);
   localparam logic [FRAC_BITS:0]  BASE_MAX   = {1'b1, {FRAC_BITS{1'b0}}};
   localparam logic [ADDR_WIDTH:0] DEPTH_W    = (ADDR_WIDTH+1)'(PB_DEPTH);
   localparam logic [CNT_W-1:0]    FILL_END   = CNT_W'(NUM_PE - 1);
   localparam logic [CNT_W-1:0]    SHIFT_END  = CNT_W'(SHIFT_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FILL_LAST,
      S_SHIFT,
      S_SHIFT_LAST
   } state_t;

   state_t                       state, state_nx;
   // One bit wider than pb_addr so it can saturate at PB_DEPTH even when PB_DEPTH == 2**ADDR_WIDTH.
   logic [ADDR_WIDTH:0]          addr;
   logic [CNT_W-1:0]             cnt;
   logic [FRAC_BITS-1:0]         frac;
   logic [FRAC_BITS:0]           base;
   logic                         pending;   // a sample arrives this cycle
   logic                         pend_rd;   // ...and it came from a real read (else it is zero)
   logic [NUM_PE*DATA_WIDTH-1:0] chain;

   logic [FRAC_BITS:0]           sum;
   logic                         carry;
   logic                         in_range;
   logic                         rd_en;
   logic [DATA_WIDTH-1:0]        new_sample;
   logic [FRAC_BITS:0]           base_clamped;

   always_comb begin
      state_nx     = state;
      rd_en        = 1'b0;
      sum          = {1'b0, frac} + base;
      carry        = (state == S_SHIFT) && sum[FRAC_BITS];
      in_range     = addr < DEPTH_W;
      new_sample   = pend_rd ? bus.pb_data : '0;
      base_clamped = (bus.sh_accu_base > BASE_MAX) ? BASE_MAX : bus.sh_accu_base;
      case (state)
         S_IDLE: begin
            if (bus.sh_fill_kick)
               state_nx = S_FILL;
            else if (bus.sh_shift_kick)
               state_nx = S_SHIFT;
         end
         S_FILL: begin
            rd_en = 1'b1;
            if (cnt == FILL_END)
               state_nx = S_FILL_LAST;
         end
         S_FILL_LAST:  state_nx = S_IDLE;
         S_SHIFT: begin
            rd_en = carry && in_range;
            if (cnt == SHIFT_END)
               state_nx = S_SHIFT_LAST;
         end
         S_SHIFT_LAST: state_nx = S_IDLE;
         default:      state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         addr    <= '0;
         cnt     <= '0;
         frac    <= '0;
         base    <= '0;
         pending <= 1'b0;
         pend_rd <= 1'b0;
         chain   <= '0;
      end else begin
         state   <= state_nx;
         pending <= 1'b0;
         pend_rd <= 1'b0;
         // Lane 0 falls off the low end; the arriving sample enters the top lane.
         if (pending)
            chain <= {new_sample, chain[NUM_PE*DATA_WIDTH-1:DATA_WIDTH]};
         case (state)
            S_IDLE: begin
               if (bus.sh_fill_kick) begin
                  addr <= '0;
                  cnt  <= '0;
               end else if (bus.sh_shift_kick) begin
                  cnt  <= '0;
                  frac <= '0;
                  base <= base_clamped;
               end
            end
            S_FILL: begin
               addr    <= addr + 1'b1;
               cnt     <= cnt + 1'b1;
               pending <= 1'b1;
               pend_rd <= 1'b1;
            end
            S_SHIFT: begin
               cnt  <= cnt + 1'b1;
               frac <= sum[FRAC_BITS-1:0];
               if (carry) begin
                  // Past the buffer end the chain still advances, but with a zero sample.
                  pending <= 1'b1;
                  pend_rd <= in_range;
                  if (in_range)
                     addr <= addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pb_en         = rd_en;
   assign bus.pb_addr       = addr[ADDR_WIDTH-1:0];
   assign bus.pe_data       = chain;
   assign bus.pe_shift      = pending;
   assign bus.sh_fill_done  = (state == S_FILL_LAST);
   assign bus.sh_shift_done = (state == S_SHIFT_LAST);
endmodule

// File: tb/tb_nabp_shifter.sv
// tb/tb_nabp_shifter.sv - bench for nabp_shifter: two instances (buffer depth 16 and 6) driven in lockstep
module tb_nabp_shifter;
   localparam int DW = 16;
   localparam int NPE = 4;
   localparam int AW = 9;
   localparam int FB = 4;
   localparam int SL = 8;
   localparam int ONE = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic fill_kick = 1'b0;
   logic shift_kick = 1'b0;
   logic [FB:0] accu_base = '0;

   always #5 clk = ~clk;

   nabp_shifter_if #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .FRAC_BITS(FB)) if_a ();
   nabp_shifter_if #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .FRAC_BITS(FB)) if_b ();

   nabp_shifter #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .PB_DEPTH(16),
                  .SHIFT_LEN(SL), .FRAC_BITS(FB))
      dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
   nabp_shifter #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .PB_DEPTH(6),
                  .SHIFT_LEN(SL), .FRAC_BITS(FB))
      dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));

   assign if_a.sh_fill_kick  = fill_kick;
   assign if_a.sh_shift_kick = shift_kick;
   assign if_a.sh_accu_base  = accu_base;
   assign if_b.sh_fill_kick  = fill_kick;
   assign if_b.sh_shift_kick = shift_kick;
   assign if_b.sh_accu_base  = accu_base;

   // Projection buffer model: mem[k] = k+1, one-cycle read latency.
   always @(posedge clk) begin
      if (if_a.pb_en) if_a.pb_data <= 16'(if_a.pb_addr) + 16'd1;
      if (if_b.pb_en) if_b.pb_data <= 16'(if_b.pb_addr) + 16'd1;
   end

   logic [1:0]         o_en, o_ps, o_fd, o_sd;
   logic [AW-1:0]      o_addr [2];
   logic [NPE*DW-1:0]  o_pe [2];
   assign o_en   = {if_b.pb_en, if_a.pb_en};
   assign o_ps   = {if_b.pe_shift, if_a.pe_shift};
   assign o_fd   = {if_b.sh_fill_done, if_a.sh_fill_done};
   assign o_sd   = {if_b.sh_shift_done, if_a.sh_shift_done};
   assign o_addr[0] = if_a.pb_addr;
   assign o_addr[1] = if_b.pb_addr;
   assign o_pe[0]   = if_a.pe_data;
   assign o_pe[1]   = if_b.pe_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: buffer depth, read pointer and chain contents per instance.
   int depth [2] = '{16, 6};
   int m_addr [2];
   int m_chain [2][NPE];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_addr[i] = 0;
         for (int k = 0; k < NPE; k++) m_chain[i][k] = 0;
      end
   endfunction

   function automatic void model_push(input int i, input int s);
      for (int k = 0; k < NPE - 1; k++) m_chain[i][k] = m_chain[i][k + 1];
      m_chain[i][NPE - 1] = s;
   endfunction

   function automatic logic [NPE*DW-1:0] model_lanes(input int i);
      logic [NPE*DW-1:0] v;
      for (int k = 0; k < NPE; k++) v[k*DW +: DW] = DW'(m_chain[i][k]);
      return v;
   endfunction

   // Fill pass starting at the current negedge (cycle 0); ends at the negedge of cycle NPE+2.
   task automatic op_fill(input bit both_kicks, input bit mid_shift_kick, input string tag);
      logic [3:0] got, want;
      fill_kick  = 1'b1;
      shift_kick = both_kicks;
      accu_base  = FB'($urandom_range(0, 31));
      for (int c = 1; c <= NPE + 2; c++) begin
         @(negedge clk);
         fill_kick  = 1'b0;
         shift_kick = mid_shift_kick && (c == 2);
         for (int i = 0; i < 2; i++) begin
            got  = {o_en[i], o_ps[i], o_fd[i], o_sd[i]};
            want = {c <= NPE, c >= 2 && c <= NPE + 1, c == NPE + 1, 1'b0};
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL %s status c%0d dut%0d {en,ps,fd,sd} got %b want %b", tag, c, i, got, want);
            end
            n_cmp++;
            if (int'(o_addr[i]) != ((c <= NPE) ? c - 1 : NPE)) begin
               n_bad++;
               $display("FAIL %s pb_addr c%0d dut%0d got %0d want %0d", tag, c, i, o_addr[i],
                        (c <= NPE) ? c - 1 : NPE);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < NPE; k++) model_push(i, k + 1);
         m_addr[i] = NPE;
         n_cmp++;
         if (o_pe[i] !== model_lanes(i)) begin
            n_bad++;
            $display("FAIL %s lanes dut%0d got %h want %h", tag, i, o_pe[i], model_lanes(i));
         end
      end
   endtask

   // Shift pass with the given base; ends at the negedge of cycle SL+2.
   task automatic op_shift(input int base, input string tag);
      bit         e_en [2][SL + 3];
      bit         e_ps [2][SL + 3];
      int         e_addr [2][SL + 3];
      int         beff, frac;
      logic [3:0] got, want;
      beff = (base > ONE) ? ONE : base;
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < SL + 3; c++) begin
            e_en[i][c] = 1'b0;
            e_ps[i][c] = 1'b0;
         end
         frac = 0;
         for (int c = 1; c <= SL; c++) begin
            e_addr[i][c] = m_addr[i];
            frac += beff;
            if (frac >= ONE) begin
               frac -= ONE;
               e_ps[i][c + 1] = 1'b1;
               if (m_addr[i] < depth[i]) begin
                  e_en[i][c] = 1'b1;
                  model_push(i, m_addr[i] + 1);
                  m_addr[i]++;
               end else begin
                  model_push(i, 0);
               end
            end
         end
         e_addr[i][SL + 1] = m_addr[i];
         e_addr[i][SL + 2] = m_addr[i];
      end
      shift_kick = 1'b1;
      fill_kick  = 1'b0;
      accu_base  = (FB + 1)'(base);
      for (int c = 1; c <= SL + 2; c++) begin
         @(negedge clk);
         shift_kick = 1'b0;
         accu_base  = (FB + 1)'($urandom_range(0, 31));
         for (int i = 0; i < 2; i++) begin
            got  = {o_en[i], o_ps[i], o_fd[i], o_sd[i]};
            want = {e_en[i][c], e_ps[i][c], 1'b0, c == SL + 1};
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL %s status c%0d dut%0d {en,ps,fd,sd} got %b want %b", tag, c, i, got, want);
            end
            n_cmp++;
            if (int'(o_addr[i]) != e_addr[i][c]) begin
               n_bad++;
               $display("FAIL %s pb_addr c%0d dut%0d got %0d want %0d", tag, c, i, o_addr[i], e_addr[i][c]);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (o_pe[i] !== model_lanes(i)) begin
            n_bad++;
            $display("FAIL %s lanes dut%0d got %h want %h", tag, i, o_pe[i], model_lanes(i));
         end
      end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({o_en[i], o_ps[i], o_fd[i], o_sd[i]} !== 4'b0 || o_addr[i] !== '0 || o_pe[i] !== '0) begin
               n_bad++;
               $display("FAIL reset dut%0d got en%b ps%b fd%b sd%b addr%0d pe%h want all zero",
                        i, o_en[i], o_ps[i], o_fd[i], o_sd[i], o_addr[i], o_pe[i]);
            end
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_fill();
      op_fill(1'b0, 1'b0, "fill");
   endtask

   task automatic test_full_rate();
      op_fill(1'b0, 1'b0, "fill_pre_full");
      op_shift(16, "full_rate");
   endtask

   task automatic test_half_rate();
      op_fill(1'b0, 1'b0, "fill_pre_half");
      op_shift(8, "half_rate");
      op_fill(1'b0, 1'b0, "fill_pre_zero");
      op_shift(0, "zero_base");
   endtask

   task automatic test_buffer_end();
      op_fill(1'b0, 1'b0, "fill_pre_end");
      op_shift(16, "buffer_end");
      op_shift(31, "past_end_clamped");
   endtask

   task automatic test_arbitration();
      op_fill(1'b1, 1'b0, "both_kicks");
      op_fill(1'b0, 1'b1, "kick_in_fill");
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({o_en[i], o_fd[i], o_sd[i]} !== 3'b0) begin
               n_bad++;
               $display("FAIL ignored_kick dut%0d {en,fd,sd} got %b want 000", i, {o_en[i], o_fd[i], o_sd[i]});
            end
         end
      end
   endtask

   task automatic test_async_reset();
      fill_kick = 1'b1;
      @(negedge clk);
      fill_kick = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (o_en[i] !== 1'b1 || int'(o_addr[i]) != 1 || o_ps[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset dut%0d got en%b addr%0d ps%b want en1 addr1 ps1",
                     i, o_en[i], o_addr[i], o_ps[i]);
         end
      end
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({o_en[i], o_ps[i], o_fd[i], o_sd[i]} !== 4'b0 || o_addr[i] !== '0 || o_pe[i] !== '0) begin
            n_bad++;
            $display("FAIL async_reset dut%0d got en%b ps%b fd%b sd%b addr%0d pe%h want all zero",
                     i, o_en[i], o_ps[i], o_fd[i], o_sd[i], o_addr[i], o_pe[i]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      op_fill(1'b0, 1'b0, "refill");
   endtask

   task automatic test_random();
      int op;
      for (int n = 0; n < 16; n++) begin
         op = $urandom_range(0, 3);
         if (op == 0) op_fill(1'b0, 1'b0, "rand_fill");
         else op_shift($urandom_range(0, 31), "rand_shift");
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_rate();
      test_half_rate();
      test_buffer_end();
      test_arbitration();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout compared %0d want run to complete", n_cmp);
      $fatal(1);
   end
endmodule
